uart_tx_mmio: RTL and testbench

- Memory-mapped UART transmitter that sits directly downstream of the RV32I multicycle CPU's single memory port.
- Decodes CPU stores (MemWrite, Mem_WrAddr, Mem_WrData) in its address window and queues bytes in a small FIFO.
- Serialises the queued bytes 8N1 on `tx`.
- Supplies combinational read data for the system read mux feeding Mem_RdData. Reads have no side effects, so the CPU's multi-cycle address hold is harmless.

---
 rtl/uart_tx_mmio_pkg.sv | 31 +++
 rtl/uart_tx_mmio_if.sv | 16 +
 rtl/uart_tx_mmio_sync_fifo.sv | 54 +++++
 rtl/uart_tx_mmio.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_mmio_pkg.sv
// uart_tx_pkg: shared constants for the memory-mapped UART transmitter.
//   - register word offsets (Mem_WrAddr[3:2])
//   - STATUS / CTRL bit positions
//   - transmit FSM state encoding
package uart_tx_pkg;

   localparam logic [1:0] OFF_TXDATA = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_CTRL   = 2'd2;

   // STATUS bits
   localparam int ST_BUSY    = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_EMPTY   = 2;
   localparam int ST_OVF     = 3;
   localparam int ST_CNT_LSB = 8;

   // CTRL bits
   localparam int CT_TX_EN    = 0;
   localparam int CT_FIFO_CLR = 1;
   localparam int CT_OVF_CLR  = 2;
   localparam int CT_IRQ_EN   = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/uart_tx_mmio_if.sv
// uart_tx_mmio_if: CPU memory-port view of the UART register window.
//   MemWrite   - store strobe (CPU -> device)
//   Mem_WrAddr - address for both reads and writes (CPU -> device)
//   Mem_WrData - store data (CPU -> device)
//   hit        - address falls in the device window (device -> CPU)
//   rd_data    - combinational read data, 0 on a miss (device -> CPU)
interface uart_tx_mmio_if;
   logic        MemWrite;
   logic [31:0] Mem_WrAddr;
   logic [31:0] Mem_WrData;
   logic        hit;
   logic [31:0] rd_data;

   modport master (output MemWrite, Mem_WrAddr, Mem_WrData, input hit, rd_data);
   modport slave  (input MemWrite, Mem_WrAddr, Mem_WrData, output hit, rd_data);
endinterface

// File: rtl/uart_tx_mmio_sync_fifo.sv
// sync_fifo: single-clock FIFO, synchronous active-high reset.
//   push/din - enqueue; accepted when not full, or when full with a pop
//   pop      - dequeue head (ignored when empty)
//   clear    - empty the FIFO; a concurrent push is discarded
//   dout     - current head, full, empty, count (0..DEPTH)
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   input  logic                     clear,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; only pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push && !clear && !reset) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter on the CPU memory port.
//   clk, reset - system clock, synchronous active-high reset
//   bus        - slave side of uart_tx_mmio_if (store decode + read mux data)
//   tx         - registered serial output, idles high
//   irq        - registered; irq_en && FIFO empty && FSM idle
module uart_tx_mmio
   import uart_tx_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
   parameter int          CLKS_PER_BIT = 868,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic           clk,
   input  logic           reset,
   uart_tx_mmio_if.slave  bus,
   output logic           tx,
   output logic           irq
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);

   logic [1:0]    off;
   logic          we, push, ctrl_we, fifo_clr, ovf_clr, pop;
   logic [7:0]    fifo_dout;
   logic          fifo_full, fifo_empty, empty_nxt;
   logic [CW-1:0] fifo_count;
   logic          tx_en, irq_en, irq_en_nxt, overflow;

   tx_state_e     state, state_nxt;
   logic [BW-1:0] baud_cnt, baud_nxt;
   logic [2:0]    bit_idx, bit_nxt;
   logic [7:0]    shift, shift_nxt;
   logic          tx_nxt;

   logic          unused_bits;
   assign unused_bits = &{1'b0, bus.Mem_WrAddr[1:0], bus.Mem_WrData[31:8]};

   // ---- decode ----
   assign off      = bus.Mem_WrAddr[3:2];
   assign bus.hit  = (bus.Mem_WrAddr[31:4] == BASE_ADDR[31:4]);
   assign we       = bus.MemWrite & bus.hit;
   assign push     = we && (off == OFF_TXDATA);
   assign ctrl_we  = we && (off == OFF_CTRL);
   assign fifo_clr = ctrl_we & bus.Mem_WrData[CT_FIFO_CLR];
   assign ovf_clr  = ctrl_we & bus.Mem_WrData[CT_OVF_CLR];
   assign pop      = (state == IDLE) && tx_en && !fifo_empty;

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (bus.Mem_WrData[7:0]),
      .pop   (pop),
      .clear (fifo_clr),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Post-edge values feeding the registered irq.
   assign irq_en_nxt = ctrl_we ? bus.Mem_WrData[CT_IRQ_EN] : irq_en;
   assign empty_nxt  = fifo_clr
                     | (fifo_empty & ~push)
                     | ((fifo_count == CW'(1)) & pop & ~push);

   // ---- CTRL / overflow ----
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_en    <= 1'b1;
         irq_en   <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (ctrl_we) begin
            tx_en  <= bus.Mem_WrData[CT_TX_EN];
            irq_en <= bus.Mem_WrData[CT_IRQ_EN];
         end
         // A dropped push wins over a concurrent clear request.
         if (push && fifo_full && !pop && !fifo_clr) overflow <= 1'b1;
         else if (ovf_clr)                            overflow <= 1'b0;
      end
   end

   // ---- transmit FSM ----
   always_comb begin
      state_nxt = state;
      baud_nxt  = baud_cnt;
      bit_nxt   = bit_idx;
      shift_nxt = shift;
      tx_nxt    = tx;
      case (state)
         IDLE: begin
            tx_nxt = 1'b1;
            if (pop) begin
               shift_nxt = fifo_dout;
               tx_nxt    = 1'b0;
               baud_nxt  = BAUD_LOAD;
               state_nxt = START;
            end
         end
         START: begin
            if (baud_cnt == '0) begin
               tx_nxt    = shift[0];
               baud_nxt  = BAUD_LOAD;
               bit_nxt   = 3'd0;
               state_nxt = DATA;
            end else baud_nxt = baud_cnt - BW'(1);
         end
         DATA: begin
            if (baud_cnt == '0) begin
               baud_nxt = BAUD_LOAD;
               if (bit_idx == 3'd7) begin
                  tx_nxt    = 1'b1;
                  state_nxt = STOP;
               end else begin
                  shift_nxt = shift >> 1;
                  tx_nxt    = shift[1];
                  bit_nxt   = bit_idx + 3'd1;
               end
            end else baud_nxt = baud_cnt - BW'(1);
         end
         STOP: begin
            if (baud_cnt == '0) state_nxt = IDLE;
            else                baud_nxt  = baud_cnt - BW'(1);
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         tx       <= 1'b1;
         irq      <= 1'b0;
      end else begin
         state    <= state_nxt;
         baud_cnt <= baud_nxt;
         bit_idx  <= bit_nxt;
         shift    <= shift_nxt;
         tx       <= tx_nxt;
         irq      <= irq_en_nxt & empty_nxt & (state_nxt == IDLE);
      end
   end

   // ---- read mux ----
   always_comb begin
      bus.rd_data = '0;
      if (bus.hit) begin
         case (off)
            OFF_STATUS: begin
               bus.rd_data[ST_BUSY]                  = (state != IDLE);
               bus.rd_data[ST_FULL]                  = fifo_full;
               bus.rd_data[ST_EMPTY]                 = fifo_empty;
               bus.rd_data[ST_OVF]                   = overflow;
               bus.rd_data[ST_CNT_LSB+4:ST_CNT_LSB]  = 5'(fifo_count);
            end
            OFF_CTRL: begin
               bus.rd_data[CT_TX_EN]  = tx_en;
               bus.rd_data[CT_IRQ_EN] = irq_en;
            end
            default: bus.rd_data = '0;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_mmio.sv
module tb_uart_tx_mmio;
   logic clk = 1'b0;
   logic reset;
   logic tx, irq;
   int   errors = 0;
   int   checks = 0;

   localparam logic [31:0] A_TX   = 32'h1000;
   localparam logic [31:0] A_ST   = 32'h1004;
   localparam logic [31:0] A_CTRL = 32'h1008;

   uart_tx_mmio_if bus ();

   uart_tx_mmio #(
      .BASE_ADDR    (32'h0000_1000),
      .CLKS_PER_BIT (4),
      .FIFO_DEPTH   (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .tx    (tx),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.MemWrite   = 1'b1;
      bus.Mem_WrAddr = a;
      bus.Mem_WrData = d;
      @(negedge clk);
      bus.MemWrite   = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
      bus.Mem_WrAddr = a;
      #1;
      chk(tag, bus.rd_data, exp);
   endtask

   function automatic logic exp_bit(input logic [7:0] b, input int k);
      if (k < 4)  return 1'b0;
      if (k < 36) return b[k/4 - 1];
      return 1'b1;
   endfunction

   // Called at the negedge just before the pop edge; returns at the negedge
   // after the frame-end edge (FSM back in IDLE).
   task automatic frame(input string tag, input logic [7:0] b, input bit inj, input bit irq_end);
      bus.Mem_WrAddr = A_ST;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         chk({tag, "_tx"}, {31'b0, tx}, {31'b0, exp_bit(b, k)});
         if (k == 0 || k == 39) chk({tag, "_busy"}, {31'b0, bus.rd_data[0]}, 32'd1);
         if (k == 0 || k == 20 || k == 39) chk({tag, "_irq_busy"}, {31'b0, irq}, 32'd0);
         if (inj && k == 9) begin
            bus.MemWrite   = 1'b1;
            bus.Mem_WrAddr = A_CTRL;
            bus.Mem_WrData = 32'h3;
         end
         if (inj && k == 10) begin
            bus.MemWrite   = 1'b0;
            bus.Mem_WrAddr = A_ST;
         end
      end
      @(negedge clk);
      chk({tag, "_end_tx"}, {31'b0, tx}, 32'd1);
      chk({tag, "_end_busy"}, {31'b0, bus.rd_data[0]}, 32'd0);
      chk({tag, "_end_irq"}, {31'b0, irq}, {31'b0, irq_end});
   endtask

   task automatic stay_idle(input string tag, input int n);
      int lows = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      chk(tag, lows, 32'd0);
   endtask

   initial begin
      reset          = 1'b1;
      bus.MemWrite   = 1'b0;
      bus.Mem_WrAddr = 32'h0;
      bus.Mem_WrData = 32'h0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // reset state
      chk("rst_tx", {31'b0, tx}, 32'd1);
      chk("rst_irq", {31'b0, irq}, 32'd0);
      rd("rst_status", A_ST, 32'h4);
      rd("rst_ctrl", A_CTRL, 32'h1);

      // single byte
      wr(A_TX, 32'h0000_00A5);
      frame("a5", 8'hA5, 1'b0, 1'b0);

      // fill and overflow with tx disabled
      wr(A_CTRL, 32'h0);
      wr(A_TX, 32'h55);
      wr(A_TX, 32'h66);
      wr(A_TX, 32'h77);
      wr(A_TX, 32'h88);
      wr(A_TX, 32'h99);
      rd("ovf_status", A_ST, 32'h0000_040A);
      chk("ovf_tx_held", {31'b0, tx}, 32'd1);
      wr(A_CTRL, 32'h1);
      frame("f55", 8'h55, 1'b0, 1'b0);
      frame("f66", 8'h66, 1'b0, 1'b0);
      frame("f77", 8'h77, 1'b0, 1'b0);
      frame("f88", 8'h88, 1'b0, 1'b0);
      rd("drained_status", A_ST, 32'h0000_000C);
      stay_idle("no_fifth_frame", 12);
      wr(A_CTRL, 32'h5);
      rd("ovf_cleared", A_ST, 32'h4);

      // address decode
      @(negedge clk);
      bus.MemWrite   = 1'b1;
      bus.Mem_WrAddr = 32'h2000;
      bus.Mem_WrData = 32'h11;
      #1;
      chk("miss_hit", {31'b0, bus.hit}, 32'd0);
      chk("miss_rd", bus.rd_data, 32'd0);
      @(negedge clk);
      bus.MemWrite = 1'b0;
      rd("miss_nopush", A_ST, 32'h4);
      stay_idle("miss_idle", 6);
      rd("rsvd_rd", 32'h100C, 32'h0);
      chk("rsvd_hit", {31'b0, bus.hit}, 32'd1);
      wr(A_ST, 32'hFFFF_FFFF);
      rd("status_ro", A_ST, 32'h4);
      rd("txdata_rd", A_TX, 32'h0);
      rd("ctrl_keep", A_CTRL, 32'h1);

      // FIFO clear mid-frame
      wr(A_CTRL, 32'h0);
      wr(A_TX, 32'hA1);
      wr(A_TX, 32'hB2);
      wr(A_TX, 32'hC3);
      rd("clr_queued", A_ST, 32'h0000_0300);
      wr(A_CTRL, 32'h1);
      frame("a1", 8'hA1, 1'b1, 1'b0);
      stay_idle("clr_no_more", 60);
      rd("clr_status", A_ST, 32'h4);
      rd("clr_ctrl", A_CTRL, 32'h1);

      // reset mid-frame (during data bit 3)
      wr(A_CTRL, 32'h0);
      wr(A_TX, 32'h11);
      wr(A_TX, 32'h22);
      wr(A_CTRL, 32'h1);
      for (int k = 0; k < 18; k++) begin
         @(negedge clk);
         chk("rf_tx", {31'b0, tx}, {31'b0, exp_bit(8'h11, k)});
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rf_tx_high", {31'b0, tx}, 32'd1);
      chk("rf_irq", {31'b0, irq}, 32'd0);
      rd("rf_status", A_ST, 32'h4);
      rd("rf_ctrl", A_CTRL, 32'h1);
      stay_idle("rf_idle", 20);

      // interrupt
      wr(A_CTRL, 32'h9);
      chk("irq_idle_on", {31'b0, irq}, 32'd1);
      wr(A_TX, 32'h3C);
      chk("irq_after_push", {31'b0, irq}, 32'd0);
      frame("f3c", 8'h3C, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
